regs_access_arbiter: RTL and testbench

- Sequences shared access to the general-purpose register file between the core's ex-stage writeback and a debug (JTAG) requester.
- Owns the register file's single write port and steals read port 2 for debug reads.
- Stalls the core for exactly one cycle per debug access.
- Bounds debug starvation with a deferral counter.

---
 rtl/regs_access_arbiter.sv | 135 +++++++++++++
 tb/tb_regs_access_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regs_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regs_access_arbiter
// Description : Shares the GPR file write port and read port 2 between ex-stage
//               writeback and a debug requester, stalling the core one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module regs_access_arbiter #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_DEFER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_we_i,
    input  logic [ADDR_W-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    output logic              ex_stall_o,
    input  logic [ADDR_W-1:0] id_raddr2_i,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_ack_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              rf_we_o,
    output logic [ADDR_W-1:0] rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o,
    output logic [ADDR_W-1:0] rf_raddr2_o,
    input  logic [DATA_W-1:0] rf_rdata2_i
);

    localparam int             c_CNT_W     = 8;
    localparam logic [c_CNT_W-1:0] c_MAX_DEFER = c_CNT_W'(MAX_DEFER);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_ACCESS = 3'd2,
        S_RESP   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_defer_cnt;
    logic [c_CNT_W-1:0]  w_defer_cnt_nxt;
    logic                r_lat_we;
    logic [ADDR_W-1:0]   r_lat_addr;
    logic [DATA_W-1:0]   r_lat_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_latch;
    logic                w_capture;
    logic                w_lat_addr_nz;

    assign w_lat_addr_nz = (r_lat_addr != '0);
    assign dbg_rdata_o   = r_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_defer_cnt <= '0;
            r_lat_we    <= 1'b0;
            r_lat_addr  <= '0;
            r_lat_wdata <= '0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_defer_cnt <= w_defer_cnt_nxt;
            if (w_latch) begin
                r_lat_we    <= dbg_we_i;
                r_lat_addr  <= dbg_addr_i;
                r_lat_wdata <= dbg_wdata_i;
            end
            // x0 reads return zero regardless of what the file drives.
            if (w_capture) begin
                r_rdata <= w_lat_addr_nz ? rf_rdata2_i : '0;
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_defer_cnt_nxt = r_defer_cnt;
        w_latch         = 1'b0;
        w_capture       = 1'b0;
        ex_stall_o      = 1'b0;
        dbg_ack_o       = 1'b0;
        rf_we_o         = ex_we_i;
        rf_waddr_o      = ex_waddr_i;
        rf_wdata_o      = ex_wdata_i;
        rf_raddr2_o     = id_raddr2_i;

        case (r_state)
            S_IDLE: begin
                if (dbg_req_i) begin
                    w_latch         = 1'b1;
                    w_defer_cnt_nxt = '0;
                    w_state_nxt     = S_ARB;
                end
            end
            S_ARB: begin
                // Debug yields to ex writes until the starvation bound is hit.
                if (!ex_we_i || (r_defer_cnt == c_MAX_DEFER)) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_defer_cnt_nxt = r_defer_cnt + 1'b1;
                end
            end
            S_ACCESS: begin
                ex_stall_o  = 1'b1;
                rf_raddr2_o = r_lat_addr;
                rf_we_o     = r_lat_we && w_lat_addr_nz;
                rf_waddr_o  = r_lat_addr;
                rf_wdata_o  = r_lat_wdata;
                w_capture   = !r_lat_we;
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                dbg_ack_o   = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!dbg_req_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regs_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regs_access_arbiter
// Description : Randomized directed bench for regs_access_arbiter with a
//               transaction-level reference model and register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regs_access_arbiter;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int MAX_DEFER = 8;
    localparam int c_LEN     = 48;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_we_i;
    logic [ADDR_W-1:0] ex_waddr_i;
    logic [DATA_W-1:0] ex_wdata_i;
    logic              ex_stall_o;
    logic [ADDR_W-1:0] id_raddr2_i;
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_wdata_i;
    logic              dbg_ack_o;
    logic [DATA_W-1:0] dbg_rdata_o;
    logic              rf_we_o;
    logic [ADDR_W-1:0] rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [ADDR_W-1:0] rf_raddr2_o;
    logic [DATA_W-1:0] rf_rdata2_i;

    always #5 clk = ~clk;

    regs_access_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_DEFER (MAX_DEFER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .ex_stall_o  (ex_stall_o),
        .id_raddr2_i (id_raddr2_i),
        .dbg_req_i   (dbg_req_i),
        .dbg_we_i    (dbg_we_i),
        .dbg_addr_i  (dbg_addr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ack_o   (dbg_ack_o),
        .dbg_rdata_o (dbg_rdata_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .rf_raddr2_o (rf_raddr2_o),
        .rf_rdata2_i (rf_rdata2_i)
    );

    // Register file environment: x0 hardwired to zero.
    logic [DATA_W-1:0] mem [32] = '{default: '0};
    assign rf_rdata2_i = mem[rf_raddr2_o];
    always @(posedge clk) begin
        if (rf_we_o && (rf_waddr_o != '0)) mem[rf_waddr_o] <= rf_wdata_o;
    end

    // Reference architectural state.
    logic [DATA_W-1:0] ref_mem [32] = '{default: '0};
    logic [DATA_W-1:0] exp_rdata = '0;

    logic              e_we   [c_LEN];
    logic [ADDR_W-1:0] e_addr [c_LEN];
    logic [DATA_W-1:0] e_data [c_LEN];
    logic [ADDR_W-1:0] id_a   [c_LEN];

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode: 0 = ex idle, 1 = ex writing x3 every cycle, 2 = random ex traffic
    task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int mode,
                           input int hold, input logic [ADDR_W-1:0] id_fix,
                           input logic id_random);
        int a;
        int nc;
        int j;
        logic exp_we;
        for (int k = 0; k < c_LEN; k++) begin
            e_we[k]   = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
            e_addr[k] = (mode == 1) ? 5'd3 : 5'($urandom);
            e_data[k] = $urandom;
            id_a[k]   = id_random ? 5'($urandom) : id_fix;
        end
        // ARB starts one cycle after the sample; debug wins on the first
        // ex-idle cycle or once MAX_DEFER cycles have been lost.
        j = 0;
        while (e_we[1 + j] && (j < MAX_DEFER)) j++;
        a = 2 + j;
        e_we[a + 1]   = e_we[a];
        e_addr[a + 1] = e_addr[a];
        e_data[a + 1] = e_data[a];
        id_a[a + 1]   = id_a[a];
        nc = a + hold + 4;

        for (int k = 0; k < nc; k++) begin
            ex_we_i     = e_we[k];
            ex_waddr_i  = e_addr[k];
            ex_wdata_i  = e_data[k];
            id_raddr2_i = id_a[k];
            if (k == 0) begin
                dbg_req_i   = 1'b1;
                dbg_we_i    = we;
                dbg_addr_i  = addr;
                dbg_wdata_i = wdata;
            end else begin
                dbg_req_i   = (k <= a + 1 + hold);
                dbg_we_i    = 1'($urandom);
                dbg_addr_i  = 5'($urandom);
                dbg_wdata_i = $urandom;
            end
            @(negedge clk);
            exp_we = (k == a) ? (we && (addr != '0)) : e_we[k];
            check("stall", 32'(ex_stall_o), 32'(k == a));
            check("ack", 32'(dbg_ack_o), 32'(k == a + 1));
            check("raddr2", 32'(rf_raddr2_o), 32'((k == a) ? addr : id_a[k]));
            check("rf_we", 32'(rf_we_o), 32'(exp_we));
            if (exp_we) begin
                check("waddr", 32'(rf_waddr_o), 32'((k == a) ? addr : e_addr[k]));
                check("wdata", rf_wdata_o, (k == a) ? wdata : e_data[k]);
            end
            check("rdata", dbg_rdata_o, exp_rdata);
            @(posedge clk);
            if (k == a && !we) exp_rdata = (addr == '0) ? '0 : ref_mem[addr];
            if (exp_we) begin
                if (k == a) ref_mem[addr] = wdata;
                else if (e_addr[k] != '0) ref_mem[e_addr[k]] = e_data[k];
            end
            #1;
        end
        dbg_req_i = 1'b0;
        ex_we_i   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        ex_we_i     = 1'b0;
        ex_waddr_i  = '0;
        ex_wdata_i  = '0;
        id_raddr2_i = '0;
        dbg_req_i   = 1'b0;
        dbg_we_i    = 1'b0;
        dbg_addr_i  = '0;
        dbg_wdata_i = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state and transparency while held in reset.
        ex_we_i     = 1'b1;
        ex_waddr_i  = 5'd9;
        ex_wdata_i  = 32'hA5A5_0001;
        id_raddr2_i = 5'd12;
        @(negedge clk);
        check("rst_stall", 32'(ex_stall_o), 32'd0);
        check("rst_ack", 32'(dbg_ack_o), 32'd0);
        check("rst_rdata", dbg_rdata_o, 32'd0);
        check("rst_we", 32'(rf_we_o), 32'd1);
        check("rst_waddr", 32'(rf_waddr_o), 32'd9);
        check("rst_wdata", rf_wdata_o, 32'hA5A5_0001);
        check("rst_raddr2", 32'(rf_raddr2_o), 32'd12);
        @(posedge clk);
        #1;
        ex_we_i = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;

        run_txn(1'b1, 5'd5, 32'hDEAD_BEEF, 0, 0, 5'd7, 1'b0);
        run_txn(1'b0, 5'd5, 32'h0, 0, 0, 5'd7, 1'b0);
        run_txn(1'b1, 5'd9, 32'h0BAD_F00D, 1, 0, 5'd7, 1'b0);
        run_txn(1'b0, 5'd9, 32'h0, 1, 0, 5'd2, 1'b0);
        run_txn(1'b1, 5'd0, 32'h0000_1234, 0, 0, 5'd7, 1'b0);
        run_txn(1'b0, 5'd0, 32'h0, 0, 0, 5'd7, 1'b0);
        run_txn(1'b0, 5'd5, 32'h0, 0, 5, 5'd7, 1'b0);
        run_txn(1'b1, 5'd6, 32'h1357_9BDF, 0, 0, 5'd1, 1'b0);

        for (int t = 0; t < 24; t++) begin
            run_txn(1'($urandom), 5'($urandom), $urandom, 2,
                    int'($urandom_range(0, 3)), 5'd0, 1'b1);
        end

        // Reset landing on the ACCESS cycle of a debug write.
        dbg_req_i   = 1'b1;
        dbg_we_i    = 1'b1;
        dbg_addr_i  = 5'd11;
        dbg_wdata_i = 32'hC0FF_EE11;
        ex_we_i     = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("racc_stall", 32'(ex_stall_o), 32'd1);
        check("racc_we", 32'(rf_we_o), 32'd1);
        check("racc_waddr", 32'(rf_waddr_o), 32'd11);
        @(posedge clk);
        ref_mem[11] = 32'hC0FF_EE11;
        exp_rdata   = '0;
        #1;
        rst       = 1'b0;
        dbg_req_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rpost_we", 32'(rf_we_o), 32'd0);
            check("rpost_stall", 32'(ex_stall_o), 32'd0);
            check("rpost_ack", 32'(dbg_ack_o), 32'd0);
            check("rpost_rdata", dbg_rdata_o, 32'd0);
            @(posedge clk);
            #1;
        end
        run_txn(1'b0, 5'd6, 32'h0, 0, 0, 5'd4, 1'b0);
        run_txn(1'b0, 5'd11, 32'h0, 2, 1, 5'd4, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
